// File: rtl/tmds_enc_mc.sv
`default_nettype none
// ============================================================================
// Module   : tmds_enc_mc
// Brief    : Multi-lane TMDS 8b/10b encoder, two-stage pipeline, shared de.
//            Define TMDS_ENC_MC_GUARD_BAND_EN for HDMI video guard-band
//            insertion (adds two output stages).
// Revision : 1.0 - initial release
// ============================================================================
module tmds_enc_mc #(
    parameter int         CHANNELS    = 3,
    parameter logic [7:0] GB_ODD_MASK = 8'b0000_0010
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    de_i,
    input  logic [8*CHANNELS-1:0]   data_i,
    input  logic [2*CHANNELS-1:0]   ctrl_i,
    output logic                    valid_o,
    output logic [10*CHANNELS-1:0]  tmds_o,
    output logic [5*CHANNELS-1:0]   disp_o
);

    localparam logic [9:0] C_SYM_CTRL0 = 10'b1101010100;
    localparam logic [9:0] C_SYM_CTRL1 = 10'b0010101011;
    localparam logic [9:0] C_SYM_CTRL2 = 10'b0101010100;
    localparam logic [9:0] C_SYM_CTRL3 = 10'b1010101011;
    localparam logic [9:0] C_GB_ODD    = 10'b0100110011;
    localparam logic [9:0] C_GB_EVEN   = 10'b1011001100;

    logic                   r1_de;
    logic                   r2_de;
    logic [10*CHANNELS-1:0] w_s2_tmds;
    logic [5*CHANNELS-1:0]  w_s2_disp;
    logic [10*CHANNELS-1:0] w_gb_sym;
    logic                   w_gb_sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r1_de <= 1'b0;
            r2_de <= 1'b0;
        end else begin
            r1_de <= de_i;
            r2_de <= r1_de;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [7:0] w_d;
        logic [3:0] w_n1_d;
        logic       w_use_xnor;
        logic [8:0] w_qm;
        logic [8:0] r_qm;
        logic [1:0] r_ctrl;
        logic [3:0] w_n1_q;
        logic [4:0] w_bal;
        logic       w_cnt_pos;
        logic       w_cnt_neg;
        logic [9:0] w_sym;
        logic [4:0] w_cnt_next;
        logic [9:0] r_sym;
        logic [4:0] r_cnt;

        assign w_d        = data_i[8*k +: 8];
        assign w_n1_d     = 4'($countones(w_d));
        assign w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !w_d[0]);

        always_comb begin
            w_qm    = '0;
            w_qm[0] = w_d[0];
            for (int i = 1; i < 8; i++) begin
                w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_d[i]) : (w_qm[i-1] ^ w_d[i]);
            end
            w_qm[8] = ~w_use_xnor;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_qm   <= '0;
                r_ctrl <= '0;
            end else begin
                r_qm   <= w_qm;
                r_ctrl <= ctrl_i[2*k +: 2];
            end
        end

        // w_bal = N1 - N0 of the minimised word, 5-bit two's complement
        assign w_n1_q    = 4'($countones(r_qm[7:0]));
        assign w_bal     = {w_n1_q, 1'b0} - 5'd8;
        assign w_cnt_pos = !r_cnt[4] && (r_cnt != 5'd0);
        assign w_cnt_neg = r_cnt[4];

        always_comb begin
            w_sym      = C_SYM_CTRL0;
            w_cnt_next = 5'd0;
            if (!r1_de) begin
                case (r_ctrl)
                    2'b00:   w_sym = C_SYM_CTRL0;
                    2'b01:   w_sym = C_SYM_CTRL1;
                    2'b10:   w_sym = C_SYM_CTRL2;
                    default: w_sym = C_SYM_CTRL3;
                endcase
            end else if ((r_cnt == 5'd0) || (w_n1_q == 4'd4)) begin
                w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_next = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
            end else if ((w_cnt_pos && (w_n1_q > 4'd4)) || (w_cnt_neg && (w_n1_q < 4'd4))) begin
                w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_next = r_cnt + {3'b000, r_qm[8], 1'b0} - w_bal;
            end else begin
                w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_next = r_cnt + w_bal - {3'b000, ~r_qm[8], 1'b0};
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_sym <= C_SYM_CTRL0;
                r_cnt <= 5'd0;
            end else begin
                r_sym <= w_sym;
                r_cnt <= w_cnt_next;
            end
        end

        assign w_s2_tmds[10*k +: 10] = r_sym;
        assign w_s2_disp[5*k +: 5]   = r_cnt;
        assign w_gb_sym[10*k +: 10]  = GB_ODD_MASK[k] ? C_GB_ODD : C_GB_EVEN;
    end

`ifdef TMDS_ENC_MC_GUARD_BAND_EN
    // r*_real marks symbols derived from sampled inputs, so the reset filler
    // in the pipeline is never turned into a guard band.
    logic                   r1_real;
    logic                   r2_real;
    logic                   r3_real;
    logic                   r3_de;
    logic                   r4_de;
    logic [10*CHANNELS-1:0] r3_tmds;
    logic [10*CHANNELS-1:0] r4_tmds;
    logic [5*CHANNELS-1:0]  r3_disp;
    logic [5*CHANNELS-1:0]  r4_disp;

    // Stage 3 is a control symbol followed by data within the next two symbols.
    assign w_gb_sel = r3_real && !r3_de && (r2_de || r1_de);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r1_real <= 1'b0;
            r2_real <= 1'b0;
            r3_real <= 1'b0;
            r3_de   <= 1'b0;
            r4_de   <= 1'b0;
            r3_tmds <= {CHANNELS{C_SYM_CTRL0}};
            r4_tmds <= {CHANNELS{C_SYM_CTRL0}};
            r3_disp <= '0;
            r4_disp <= '0;
        end else begin
            r1_real <= 1'b1;
            r2_real <= r1_real;
            r3_real <= r2_real;
            r3_de   <= r2_de;
            r4_de   <= r3_de;
            r3_tmds <= w_s2_tmds;
            r4_tmds <= w_gb_sel ? w_gb_sym : r3_tmds;
            r3_disp <= w_s2_disp;
            r4_disp <= w_gb_sel ? '0 : r3_disp;
        end
    end

    assign valid_o = r4_de;
    assign tmds_o  = r4_tmds;
    assign disp_o  = r4_disp;
`else
    assign w_gb_sel = 1'b0;
    assign valid_o  = r2_de;
    assign tmds_o   = w_gb_sel ? w_gb_sym : w_s2_tmds;
    assign disp_o   = w_s2_disp;
`endif

endmodule
`default_nettype wire
